// File: rtl/debug_sender_scheduler_pkg.sv
// Shared encodings for the debug sender scheduler and the DebugDataSender it drives.
package debug_pkg;

  localparam int DBG_WORD_W = 40;

  // Values of the sender's state output, matching DebugDataSender.
  localparam logic STATE_EMPTY  = 1'b0;
  localparam logic STATE_STORED = 1'b1;

  typedef enum logic [2:0] {
    SCH_IDLE,
    SCH_ISSUE,
    SCH_WAIT_START,
    SCH_WAIT_DONE,
    SCH_GAP
  } sch_state_t;

  // Overwrites the top three bits of a word with the requester index.
  function automatic logic [DBG_WORD_W-1:0] tag_word(input logic [DBG_WORD_W-1:0] word,
                                                     input logic [2:0] id);
    return {id, word[DBG_WORD_W-4:0]};
  endfunction

endpackage

// File: rtl/debug_sender_scheduler_if.sv
// Requester and sender-side signals of the debug sender scheduler.
interface debug_sender_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import debug_pkg::*;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DBG_WORD_W-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic                          store;
  logic [DBG_WORD_W-1:0]         data;
  logic                          sender_state;

  modport master (
    input  req, req_data, sender_state,
    output ack, store, data
  );

  modport slave (
    output req, req_data, sender_state,
    input  ack, store, data
  );

endinterface

// File: rtl/debug_sender_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         rr_ptr,
  output logic               valid,
  output logic [2:0]         idx
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [3:0] pos;
      pos = 4'(rr_ptr) + 4'(k);
      if (pos >= 4'(NUM_REQ)) pos = pos - 4'(NUM_REQ);
      if (!valid && req[pos[IW-1:0]]) begin
        valid = 1'b1;
        idx   = pos[2:0];
      end
    end
  end

endmodule

// File: rtl/debug_sender_scheduler.sv
// Shares one DebugDataSender between NUM_REQ requesters: round-robin grant, one store
// pulse per word, then waits for the sender's frame (synchronised state) before re-arbitrating.
module debug_sender_scheduler
  import debug_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 64,
  parameter int GAP_CYCLES    = 4,
  parameter int TAG_EN        = 0
) (
  input  logic                    in_clk,
  input  logic                    reset,
  debug_sender_scheduler_if.master bus,
  output logic                    busy,
  output logic [2:0]              grant_id,
  output logic                    timeout_err,
  output logic [15:0]             sent_count
);

  localparam int CNT_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  sch_state_t            state;
  logic [CNT_W-1:0]      cnt;
  logic [2:0]            rr_ptr;
  logic                  st_meta;
  logic                  sync_st;
  logic                  store_q;
  logic [NUM_REQ-1:0]    ack_q;
  logic [DBG_WORD_W-1:0] data_q;
  logic [15:0]           sent_q;
  logic                  pick_vld;
  logic [2:0]            pick_idx;
  logic [DBG_WORD_W-1:0] raw_word;
  logic [DBG_WORD_W-1:0] pick_word;

  assign bus.store  = store_q;
  assign bus.ack    = ack_q;
  assign bus.data   = data_q;
  assign sent_count = sent_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .valid  (pick_vld),
    .idx    (pick_idx)
  );

  always_comb begin
    raw_word  = bus.req_data[int'(pick_idx)*DBG_WORD_W +: DBG_WORD_W];
    pick_word = (TAG_EN != 0) ? tag_word(raw_word, pick_idx) : raw_word;
  end

  // sender_state lives in the sender's out_clk domain.
  always_ff @(posedge in_clk) begin
    if (reset) begin
      st_meta <= 1'b0;
      sync_st <= 1'b0;
    end else begin
      st_meta <= bus.sender_state;
      sync_st <= st_meta;
    end
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      state       <= SCH_IDLE;
      cnt         <= '0;
      rr_ptr      <= 3'd0;
      store_q     <= 1'b0;
      ack_q       <= '0;
      data_q      <= '0;
      busy        <= 1'b0;
      grant_id    <= 3'd0;
      timeout_err <= 1'b0;
      sent_q      <= 16'd0;
    end else begin
      case (state)
        SCH_IDLE: begin
          if (pick_vld) begin
            grant_id <= pick_idx;
            data_q   <= pick_word;
            rr_ptr   <= (pick_idx == 3'(NUM_REQ - 1)) ? 3'd0 : pick_idx + 3'd1;
            store_q  <= 1'b1;
            ack_q    <= NUM_REQ'(1) << pick_idx;
            busy     <= 1'b1;
            state    <= SCH_ISSUE;
          end
        end
        SCH_ISSUE: begin
          store_q <= 1'b0;
          ack_q   <= '0;
          cnt     <= '0;
          state   <= SCH_WAIT_START;
        end
        SCH_WAIT_START: begin
          cnt <= cnt + CNT_W'(1);
          // A late start seen on the timeout cycle still counts as a start.
          if (sync_st == STATE_STORED) begin
            state <= SCH_WAIT_DONE;
          end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            cnt         <= '0;
            state       <= SCH_GAP;
          end
        end
        SCH_WAIT_DONE: begin
          if (sync_st == STATE_EMPTY) begin
            sent_q <= sent_q + 16'd1;
            cnt    <= '0;
            state  <= SCH_GAP;
          end
        end
        SCH_GAP: begin
          if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= SCH_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= SCH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_sender_scheduler.sv
// Bench for debug_sender_scheduler: vector table for arbitration order, scoreboard of
// expected grants/words, plus sequences for timing, fairness, timeout, tag, wrap and reset.
module tb_debug_sender_scheduler;
  import debug_pkg::*;

  localparam int NR    = 4;
  localparam int TO    = 64;
  localparam int GAP   = 4;
  localparam int FRAME = 120;  // 40 out_clk periods at 3x the in_clk period

  logic in_clk = 1'b0;
  logic reset  = 1'b1;
  always #5 in_clk = ~in_clk;

  debug_sender_scheduler_if #(.NUM_REQ(NR)) bus  ();
  debug_sender_scheduler_if #(.NUM_REQ(NR)) bus2 ();

  logic        busy, timeout_err, busy2, timeout_err2;
  logic [2:0]  grant_id, grant_id2;
  logic [15:0] sent_count, sent_count2;

  debug_sender_scheduler #(.NUM_REQ(NR), .START_TIMEOUT(TO), .GAP_CYCLES(GAP), .TAG_EN(0)) dut (
    .in_clk(in_clk), .reset(reset), .bus(bus), .busy(busy), .grant_id(grant_id),
    .timeout_err(timeout_err), .sent_count(sent_count));

  debug_sender_scheduler #(.NUM_REQ(NR), .START_TIMEOUT(TO), .GAP_CYCLES(GAP), .TAG_EN(1)) dut2 (
    .in_clk(in_clk), .reset(reset), .bus(bus2), .busy(busy2), .grant_id(grant_id2),
    .timeout_err(timeout_err2), .sent_count(sent_count2));

  typedef struct {
    logic [NR-1:0] req;
    logic [2:0]    grant;
    logic [39:0]   dat;
  } vec_t;

  typedef struct {
    logic [2:0]  grant;
    logic [39:0] data;
  } exp_t;

  vec_t tbl [10];
  exp_t sb [$];
  int   total = 0;
  int   bad   = 0;
  int   frame_len = FRAME;

  // Behavioural sender: a store starts a frame two cycles later; frame_len==0 never starts.
  initial begin
    bus.sender_state = 1'b0;
    forever begin
      @(negedge in_clk);
      if (bus.store && frame_len > 0 && !reset) begin
        repeat (2) @(negedge in_clk);
        bus.sender_state = 1'b1;
        repeat (frame_len) @(negedge in_clk);
        bus.sender_state = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_vec(input logic [NR-1:0] r, input logic [39:0] dat);
    for (int j = 0; j < NR; j++) bus.req_data[j*40 +: 40] = dat ^ 40'(j);
    bus.req = r;
  endtask

  // Returns number of negedges until store is seen (1 = the next cycle); 0 on expiry.
  task automatic wait_store(output int n);
    for (n = 1; n <= 500; n++) begin
      @(negedge in_clk);
      if (bus.store) return;
    end
    n = 0;
    check("store_wait", 0, 1);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 1000 && busy; k++) @(negedge in_clk);
    if (busy) check("idle_wait", 1, 0);
  endtask

  task automatic take_word(input string nm, output logic [2:0] g);
    int   n;
    exp_t e;
    g = 3'd7;
    wait_store(n);
    if (n == 0) return;
    if (sb.size() == 0) begin
      check({nm, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({nm, "_grant"}, grant_id, e.grant);
    check({nm, "_data"}, bus.data, e.data);
    check({nm, "_ack"}, bus.ack, 4'(1) << e.grant);
    g = grant_id;
  endtask

  initial begin
    int          n, m, exp_cnt, prev;
    logic [2:0]  g;
    logic [2:0]  fair_order [6];
    logic        spurious;

    tbl[0] = '{4'b0010, 3'd1, 40'hA9_9999_9990};
    tbl[1] = '{4'b1111, 3'd2, 40'h11_2233_4450};
    tbl[2] = '{4'b1111, 3'd3, 40'h55_6677_8890};
    tbl[3] = '{4'b1111, 3'd0, 40'h0F_0F0F_0F00};
    tbl[4] = '{4'b1111, 3'd1, 40'hF0_F0F0_F0F0};
    tbl[5] = '{4'b0001, 3'd0, 40'h12_3456_7890};
    tbl[6] = '{4'b1001, 3'd3, 40'hDE_ADBE_EF00};
    tbl[7] = '{4'b0110, 3'd1, 40'hCA_FEF0_0D10};
    tbl[8] = '{4'b0100, 3'd2, 40'h00_0000_0000};
    tbl[9] = '{4'b0011, 3'd0, 40'h80_0000_0008};
    fair_order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1};

    bus.req = '0;  bus.req_data = '0;
    bus2.req = '0; bus2.req_data = '0; bus2.sender_state = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge in_clk);
    check("rst_store", bus.store, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_data", bus.data, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_count", sent_count, 0);
    reset = 1'b0;
    @(negedge in_clk);

    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive_vec(tbl[i].req, tbl[i].dat);
      sb.push_back('{tbl[i].grant, tbl[i].dat ^ 40'(tbl[i].grant)});
      if (i == 0) begin
        wait_store(n);
        check("req_to_store_latency", n, 1);
        sb.push_front(sb.pop_front());
        // Store already seen; compare it directly from the scoreboard.
        check("v0_grant", grant_id, sb[0].grant);
        check("v0_data", bus.data, 40'hA9_9999_9991);
        check("v0_ack", bus.ack, 4'b0010);
        void'(sb.pop_front());
        bus.req = '0;
        for (n = 0; n < 500 && !dut.sync_st; n++) @(negedge in_clk);
        for (n = 0; n < 500 && dut.sync_st; n++) @(negedge in_clk);
        for (m = 0; m < 100 && busy; m++) @(negedge in_clk);
        check("busy_fall_after_sync", m, GAP + 1);
      end else begin
        take_word($sformatf("vec%0d", i), g);
        bus.req = '0;
      end
      wait_idle();
      exp_cnt++;
      check($sformatf("vec%0d_count", i), sent_count, exp_cnt);
      check($sformatf("vec%0d_data_hold", i), bus.data, tbl[i].dat ^ 40'(tbl[i].grant));
    end

    // Fairness: all requesters active, each re-raising two cycles after its ack.
    reset = 1'b1;
    @(negedge in_clk);
    reset = 1'b0;
    drive_vec(4'b1111, 40'h33_0000_0000);
    for (int k = 0; k < 6; k++) sb.push_back('{fair_order[k], 40'h33_0000_0000 ^ 40'(fair_order[k])});
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      take_word($sformatf("fair%0d", k), g);
      check($sformatf("fair%0d_no_repeat", k), (int'(g) == prev), 0);
      prev = int'(g);
      if (k < 5 && g < 3'(NR)) begin
        bus.req[g] = 1'b0;
        repeat (2) @(negedge in_clk);
        bus.req[g] = 1'b1;
      end else begin
        bus.req = '0;
      end
    end
    wait_idle();
    check("fair_count", sent_count, 6);

    // Start timeout: the sender never starts a frame.
    frame_len = 0;
    drive_vec(4'b0001, 40'h44_4444_4440);
    sb.push_back('{3'd0, 40'h44_4444_4440});
    take_word("to_word", g);
    bus.req = '0;
    for (n = 1; n <= 500; n++) begin
      @(negedge in_clk);
      if (timeout_err) break;
    end
    // Counted from the ISSUE cycle itself, so one more than the timeout length.
    check("timeout_delay", n, TO + 1);
    wait_idle();
    check("timeout_count", sent_count, 6);
    frame_len = FRAME;
    drive_vec(4'b0010, 40'h66_6666_6660);
    sb.push_back('{3'd1, 40'h66_6666_6661});
    take_word("after_to", g);
    bus.req = '0;
    wait_idle();
    check("after_to_count", sent_count, 7);
    check("timeout_sticky", timeout_err, 1);

    // Counter wrap.
    force dut.sent_q = 16'hFFFF;
    @(negedge in_clk);
    release dut.sent_q;
    check("wrap_preload", sent_count, 16'hFFFF);
    drive_vec(4'b0100, 40'h77_7777_7770);
    sb.push_back('{3'd2, 40'h77_7777_7772});
    take_word("wrap", g);
    bus.req = '0;
    wait_idle();
    check("wrap_count", sent_count, 0);

    // Reset while the sender is mid-frame.
    drive_vec(4'b0001, 40'h88_8888_8880);
    sb.push_back('{3'd0, 40'h88_8888_8880});
    take_word("mid_rst", g);
    bus.req = '0;
    for (n = 0; n < 500 && !bus.sender_state; n++) @(negedge in_clk);
    repeat (10) @(negedge in_clk);
    check("mid_rst_in_wait_done", dut.state, SCH_WAIT_DONE);
    reset = 1'b1;
    @(negedge in_clk);
    reset = 1'b0;
    check("mid_rst_store", bus.store, 0);
    check("mid_rst_ack", bus.ack, 0);
    check("mid_rst_data", bus.data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant", grant_id, 0);
    check("mid_rst_timeout", timeout_err, 0);
    check("mid_rst_count", sent_count, 0);
    check("mid_rst_rr_ptr", dut.rr_ptr, 0);
    spurious = 1'b0;
    for (n = 0; n < 500 && bus.sender_state; n++) begin
      @(negedge in_clk);
      if (bus.ack != '0 || busy || sent_count != 16'd0) spurious = 1'b1;
    end
    repeat (5) @(negedge in_clk);
    check("mid_rst_quiet", spurious, 0);
    drive_vec(4'b1111, 40'h99_9999_9990);
    sb.push_back('{3'd0, 40'h99_9999_9990});
    take_word("post_rst", g);
    bus.req = '0;
    wait_idle();
    check("post_rst_count", sent_count, 1);

    // Tagging on the TAG_EN instance.
    bus2.req_data[3*40 +: 40] = 40'hFF_FFFF_FFFF;
    bus2.req = 4'b1000;
    for (n = 1; n <= 10; n++) begin
      @(negedge in_clk);
      if (bus2.store) break;
    end
    check("tag_store_seen", bus2.store, 1);
    check("tag_data", bus2.data, 40'h7F_FFFF_FFFF);
    check("tag_grant", grant_id2, 3);
    check("tag_ack", bus2.ack, 4'b1000);
    bus2.req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_sender_scheduler.md
Name: debug_sender_scheduler

Overview:
- Round-robin scheduler that shares one DebugDataSender serial debug port between NUM_REQ on-chip requesters.
- Runs in the sender's in_clk domain. Each cycle it picks one pending 40-bit word, pulses the sender's store input, then waits for a full transmission to complete before the next grant.
- Synchronises the sender's out_clk-domain state flag, applies a start timeout, and counts completed words.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- START_TIMEOUT, 64, max in_clk cycles in WAIT_START before abandoning a word.
- GAP_CYCLES, 4, idle in_clk cycles after completion before the next store pulse (lets the sender's in_state clear).
- TAG_EN, 0, if 1 then data[39:37] is replaced by the granted requester index (zero-extended to 3 bits).

Ports:
- in_clk  input  1  single clock; the sender's in_clk.
- reset  input  1  synchronous, active-high.
- req  input  NUM_REQ  level request per requester; held with req_data until the matching ack.
- req_data  input  NUM_REQ*40  word for requester i, in bits [40*i+39:40*i].
- ack  output  NUM_REQ  one-cycle pulse; the word for that requester has been taken.
- store  output  1  to sender store; one-cycle pulse.
- data  output  40  to sender data; registered, stable from ISSUE until the next ISSUE.
- sender_state  input  1  sender state output (1 = STORED/shifting); asynchronous to in_clk.
- busy  output  1  high in any state except IDLE.
- grant_id  output  3  index of the current or last granted requester.
- timeout_err  output  1  sticky; set on a start timeout.
- sent_count  output  16  completed transmissions; wraps from 0xFFFF to 0.

Behaviour:
- Reset: state=IDLE; store=0, ack=0, data=0, busy=0, grant_id=0, timeout_err=0, sent_count=0; rr pointer=0; synchroniser flops=0. Reset mid-transfer abandons the word with no ack and no count; the sender is not touched.
- sender_state goes through a 2-flop synchroniser to sync_st. All decisions use sync_st only.
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE, GAP.
- IDLE, if any req bit is set:
  - Select the first set bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - Latch grant_id and data (apply the tag if TAG_EN).
  - Set rr_ptr = grant+1 (mod NUM_REQ).
  - Go to ISSUE.
- IDLE with no request: stay in IDLE.
- ISSUE (exactly 1 cycle): store=1 and ack[grant_id]=1; clear the timeout counter; go to WAIT_START.
  - Latency: req rising in IDLE at cycle N gives store/ack at cycle N+1.
- WAIT_START: increment the counter each cycle.
  - sync_st==1: go to WAIT_DONE.
  - Else, if counter==START_TIMEOUT-1: set timeout_err=1 and go to GAP (word lost, no count).
  - If sync_st==1 and the timeout fall on the same cycle, sync_st wins.
- WAIT_DONE: stay while sync_st==1. On sync_st==0: sent_count+=1, go to GAP.
- GAP: hold GAP_CYCLES cycles (counter reused), then go to IDLE.
- store and ack are never high outside ISSUE; at most one ack bit is high at a time.
- A req dropped before its grant is simply skipped; no ack is given.
- A req asserted during busy waits; arbitration happens only in IDLE.
- All requesters active gives strict rotation 0,1,2,3,0,...
- timeout_err is cleared only by reset.
- Steady-state throughput is one word per sender frame plus roughly 2 sync + GAP_CYCLES + 2 in_clk cycles.

Decomposition:
- Shared package (debug_pkg):
  - state encodings SCH_IDLE..SCH_GAP;
  - DBG_WORD_W = 40;
  - sender STATE_EMPTY = 0 and STATE_STORED = 1 (shared with DebugDataSender's define values).
- One sub-module: rr_arbiter (NUM_REQ-wide, combinational pick from req and rr_ptr; outputs a valid flag and an index).
- The 2-flop synchroniser is inline.

Test Plan:
- Single request: set req=4'b0010 with req_data[79:40]=40'hA9_9999_9991, a behavioural sender model (sender_state high 40 out_clks, out_clk=3x in_clk period) -> ack[1] and store in the same cycle one clock after req; data=40'hA999999991; sent_count=1; busy falls GAP_CYCLES+1 cycles after sync_st falls.
- Fairness: req=4'b1111 held, each requester dropping req after its ack and re-raising it 2 cycles later -> grant order 0,1,2,3,0,1; no requester acked twice in a row; sent_count=6 after 6 frames.
- Timeout: sender model never raises sender_state -> timeout_err=1 exactly START_TIMEOUT cycles after ISSUE; sent_count stays 0; FSM returns to IDLE after GAP and serves the next req.
- TAG_EN=1: requester 3 sends 40'hFF_FFFF_FFFF -> data=40'h7F_FFFF_FFFF (bits 39:37=3'b011).
- Reset mid-WAIT_DONE: assert reset for 1 cycle -> the next cycle has all outputs at reset values, rr_ptr=0, and no ack for the pending word.
- Wrap: preload sent_count to 0xFFFF via force and complete one frame -> sent_count=0.
